// File: rtl/phase_clock_gen.sv
// Multi-channel programmable phase generator: derives NUM_CH clock-like waveforms
// from the base clock, with handshaked configuration applied at period boundaries.
module phase_clock_gen #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned CNT_W          = 4,
   parameter int unsigned DEFAULT_PERIOD = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      run,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [CNT_W-1:0]          cfg_period,
   input  logic [NUM_CH*CNT_W-1:0]   cfg_rise,
   input  logic [NUM_CH*CNT_W-1:0]   cfg_width,
   input  logic [NUM_CH-1:0]         cfg_invert,
   output logic [NUM_CH-1:0]         phase_out,
   output logic [CNT_W-1:0]          phase_count,
   output logic                      cycle_strobe,
   output logic                      cfg_error
);

   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEFAULT_PERIOD / 2);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   state_t                    state, n_state;
   logic [CNT_W-1:0]          act_period, n_period, pnd_period;
   logic [NUM_CH*CNT_W-1:0]   act_rise, n_rise, pnd_rise;
   logic [NUM_CH*CNT_W-1:0]   act_width, n_width, pnd_width;
   logic [NUM_CH-1:0]         act_invert, n_invert, pnd_invert;
   logic [CNT_W-1:0]          n_count;
   logic [NUM_CH-1:0]         n_phase;
   logic                      accept, cfg_ok, take, wrap, n_store;
   logic [CNT_W-1:0]          r_i, w_i, d_i;

   // Offered configuration validity: period >= 2 and every rise inside the period.
   always_comb begin
      cfg_ok = (cfg_period >= CNT_W'(2));
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (cfg_rise[i*CNT_W +: CNT_W] >= cfg_period) cfg_ok = 1'b0;
      end
   end

   assign accept = cfg_valid & cfg_ready;
   assign take   = accept & cfg_ok;
   assign wrap   = (phase_count == CNT_W'(act_period - CNT_W'(1)));

   // Next state, count and active configuration.
   always_comb begin
      n_state  = state;
      n_count  = phase_count;
      n_period = act_period;
      n_rise   = act_rise;
      n_width  = act_width;
      n_invert = act_invert;
      n_store  = 1'b0;
      if (!run) begin
         n_state = IDLE;
         n_count = '0;
         if (state == PEND) begin
            n_period = pnd_period;
            n_rise   = pnd_rise;
            n_width  = pnd_width;
            n_invert = pnd_invert;
         end else if (take) begin
            n_period = cfg_period;
            n_rise   = cfg_rise;
            n_width  = cfg_width;
            n_invert = cfg_invert;
         end
      end else begin
         case (state)
            IDLE: begin
               n_state = RUN;
               n_count = '0;
               if (take) begin
                  n_period = cfg_period;
                  n_rise   = cfg_rise;
                  n_width  = cfg_width;
                  n_invert = cfg_invert;
               end
            end
            RUN: begin
               n_count = wrap ? '0 : CNT_W'(phase_count + CNT_W'(1));
               if (take) begin
                  n_state = PEND;
                  n_store = 1'b1;
               end
            end
            PEND: begin
               if (wrap) begin
                  n_count  = '0;
                  n_state  = RUN;
                  n_period = pnd_period;
                  n_rise   = pnd_rise;
                  n_width  = pnd_width;
                  n_invert = pnd_invert;
               end else begin
                  n_count = CNT_W'(phase_count + CNT_W'(1));
               end
            end
            default: n_state = IDLE;
         endcase
      end
   end

   // Waveform from next count; rise < period so the modulo is a single conditional add.
   always_comb begin
      n_phase = '0;
      r_i     = '0;
      w_i     = '0;
      d_i     = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         r_i = n_rise[i*CNT_W +: CNT_W];
         w_i = n_width[i*CNT_W +: CNT_W];
         d_i = (n_count >= r_i) ? CNT_W'(n_count - r_i)
                                : CNT_W'(n_count + CNT_W'(n_period - r_i));
         n_phase[i] = (n_state == IDLE) ? n_invert[i] : ((d_i < w_i) ^ n_invert[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         phase_count  <= '0;
         phase_out    <= '0;
         cycle_strobe <= 1'b0;
         cfg_error    <= 1'b0;
         cfg_ready    <= 1'b1;
         act_period   <= DEF_P;
         act_rise     <= '0;
         act_width    <= {NUM_CH{DEF_W}};
         act_invert   <= '0;
         pnd_period   <= '0;
         pnd_rise     <= '0;
         pnd_width    <= '0;
         pnd_invert   <= '0;
      end else begin
         state        <= n_state;
         phase_count  <= n_count;
         phase_out    <= n_phase;
         cycle_strobe <= (n_state != IDLE) && (n_count == '0);
         cfg_error    <= accept & ~cfg_ok;
         cfg_ready    <= (n_state != PEND);
         act_period   <= n_period;
         act_rise     <= n_rise;
         act_width    <= n_width;
         act_invert   <= n_invert;
         if (n_store) begin
            pnd_period <= cfg_period;
            pnd_rise   <= cfg_rise;
            pnd_width  <= cfg_width;
            pnd_invert <= cfg_invert;
         end
      end
   end

endmodule

// File: tb/tb_phase_clock_gen.sv
// Self-checking bench for phase_clock_gen: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_phase_clock_gen;
   localparam int NCH = 4;
   localparam int CW  = 4;

   logic              clock = 1'b0;
   logic              reset, run, cfg_valid, cfg_ready;
   logic [CW-1:0]     cfg_period;
   logic [NCH*CW-1:0] cfg_rise, cfg_width;
   logic [NCH-1:0]    cfg_invert, phase_out;
   logic [CW-1:0]     phase_count;
   logic              cycle_strobe, cfg_error;

   phase_clock_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_PERIOD(6)) dut (
      .clock(clock), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_rise(cfg_rise), .cfg_width(cfg_width),
      .cfg_invert(cfg_invert), .phase_out(phase_out), .phase_count(phase_count),
      .cycle_strobe(cycle_strobe), .cfg_error(cfg_error));

   initial forever #5 clock = ~clock;

   int checks = 0, failures = 0, cyc = 0;

   // model state
   int m_p, m_r[NCH], m_w[NCH];
   bit m_inv[NCH];
   int q_p, q_r[NCH], q_w[NCH];
   bit q_inv[NCH];
   bit m_running, m_pend;
   int m_cnt;
   logic [NCH-1:0] e_out;
   int  e_cnt;
   bit  e_strobe, e_err, e_ready;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit offered_ok();
      if (int'(cfg_period) < 2) return 1'b0;
      for (int i = 0; i < NCH; i++)
         if (int'(cfg_rise[i*CW +: CW]) >= int'(cfg_period)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic load_offered();
      m_p = int'(cfg_period);
      for (int i = 0; i < NCH; i++) begin
         m_r[i] = int'(cfg_rise[i*CW +: CW]);
         m_w[i] = int'(cfg_width[i*CW +: CW]);
         m_inv[i] = cfg_invert[i];
      end
   endtask

   task automatic load_pending();
      m_p = q_p;
      for (int i = 0; i < NCH; i++) begin
         m_r[i] = q_r[i]; m_w[i] = q_w[i]; m_inv[i] = q_inv[i];
      end
   endtask

   task automatic store_pending();
      q_p = int'(cfg_period);
      for (int i = 0; i < NCH; i++) begin
         q_r[i] = int'(cfg_rise[i*CW +: CW]);
         q_w[i] = int'(cfg_width[i*CW +: CW]);
         q_inv[i] = cfg_invert[i];
      end
   endtask

   // One clock edge of the behavioural model, from the inputs held across that edge.
   task automatic model_step();
      bit acc, ok, wrapped;
      if (reset) begin
         m_p = 6;
         for (int i = 0; i < NCH; i++) begin m_r[i] = 0; m_w[i] = 3; m_inv[i] = 0; end
         m_running = 0; m_pend = 0; m_cnt = 0;
         e_out = '0; e_cnt = 0; e_strobe = 0; e_err = 0; e_ready = 1;
         return;
      end
      acc = cfg_valid && e_ready;
      ok  = offered_ok();
      e_err = acc && !ok;
      if (!run) begin
         if (m_pend) load_pending();
         else if (acc && ok) load_offered();
         m_running = 0; m_pend = 0; m_cnt = 0;
      end else if (!m_running) begin
         if (acc && ok) load_offered();
         m_running = 1; m_cnt = 0;
      end else begin
         wrapped = (m_cnt == m_p - 1);
         if (m_pend && wrapped) begin load_pending(); m_pend = 0; end
         m_cnt = wrapped ? 0 : m_cnt + 1;
         if (acc && ok) begin m_pend = 1; store_pending(); end
      end
      e_cnt = m_cnt;
      e_ready = !m_pend;
      e_strobe = m_running && (m_cnt == 0);
      for (int i = 0; i < NCH; i++)
         e_out[i] = m_running ? ((((((m_cnt - m_r[i]) % m_p) + m_p) % m_p) < m_w[i]) ^ m_inv[i])
                              : m_inv[i];
   endtask

   // Advance one cycle and compare every output against the model.
   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
      cyc++;
      check("phase_count", int'(phase_count), e_cnt);
      check("phase_out", int'(phase_out), int'(e_out));
      check("cycle_strobe", int'(cycle_strobe), int'(e_strobe));
      check("cfg_error", int'(cfg_error), int'(e_err));
      check("cfg_ready", int'(cfg_ready), int'(e_ready));
   endtask

   task automatic wait_model_cnt(input int target);
      int n = 0;
      while (e_cnt != target && n < 40) begin tick(); n++; end
      if (e_cnt != target) begin
         checks++; failures++;
         $display("FAIL wait_count cycle=%0d got=%0d expected=%0d", cyc, e_cnt, target);
      end
   endtask

   initial begin
      reset = 1; run = 0; cfg_valid = 0; cfg_period = '0;
      cfg_rise = '0; cfg_width = '0; cfg_invert = '0;
      tick(); tick();
      check("rst_count", int'(phase_count), 0);
      check("rst_out", int'(phase_out), 0);
      check("rst_ready", int'(cfg_ready), 1);
      check("rst_strobe", int'(cycle_strobe), 0);

      // defaults: P=6, W=3, R=0
      reset = 0; run = 1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check("def_count", int'(phase_count), k % 6);
         check("def_out0", int'(phase_out[0]), int'((k % 6) < 3));
         check("def_strobe", int'(cycle_strobe), int'((k % 6) == 0));
      end

      // IDLE load: ch1 wrap-around window, ch2 W=0 inverted, ch3 W=15
      run = 0; tick();
      cfg_valid = 1; cfg_period = 4'd6;
      cfg_rise  = {4'd0, 4'd0, 4'd4, 4'd0};
      cfg_width = {4'd15, 4'd0, 4'd3, 4'd3};
      cfg_invert = 4'b0100;
      tick();
      check("idle_out_inv", int'(phase_out), 4);
      cfg_valid = 0; run = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("win_out1", int'(phase_out[1]), int'(k >= 4 || k == 0));
         check("w0_inv_out2", int'(phase_out[2]), 1);
         check("wfull_out3", int'(phase_out[3]), 1);
      end

      // change period to 4 mid-period
      wait_model_cnt(2);
      cfg_valid = 1; cfg_period = 4'd4; cfg_rise = '0;
      cfg_width = {4'd4, 4'd0, 4'd2, 4'd2}; cfg_invert = 4'b0100;
      for (int c = 3; c <= 5; c++) begin
         tick();
         cfg_valid = 0;
         check("pend_count", int'(phase_count), c);
         check("pend_ready", int'(cfg_ready), 0);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         check("p4_count", int'(phase_count), k % 4);
         check("p4_ready", int'(cfg_ready), 1);
      end

      // rejected configurations
      cfg_valid = 1; cfg_period = 4'd1; tick();
      check("err_p1", int'(cfg_error), 1);
      cfg_valid = 0; tick();
      check("err_p1_clear", int'(cfg_error), 0);
      cfg_valid = 1; cfg_period = 4'd6; cfg_rise = {4'd0, 4'd0, 4'd0, 4'd7}; tick();
      check("err_rise", int'(cfg_error), 1);
      check("err_ready", int'(cfg_ready), 1);
      cfg_valid = 0; tick();
      check("err_rise_clear", int'(cfg_error), 0);

      // stop mid-period
      wait_model_cnt(2);
      run = 0; tick();
      check("stop_count", int'(phase_count), 0);
      check("stop_out", int'(phase_out), 4);

      // reset while a configuration is pending
      run = 1;
      wait_model_cnt(2);
      cfg_valid = 1; cfg_period = 4'd5; cfg_rise = '0; cfg_width = {4{4'd1}}; cfg_invert = 4'b1111;
      tick();
      cfg_valid = 0;
      check("pend_before_rst", int'(cfg_ready), 0);
      reset = 1; tick();
      check("rst2_count", int'(phase_count), 0);
      check("rst2_out", int'(phase_out), 0);
      check("rst2_ready", int'(cfg_ready), 1);
      reset = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         check("rst2_def_out0", int'(phase_out[0]), int'((k % 6) < 3));
      end

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int p;
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 29) == 0) run = ~run;
         cfg_valid = ($urandom_range(0, 5) == 0);
         p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 15);
         cfg_period = CW'(p);
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 9) == 0) cfg_rise[i*CW +: CW] = CW'($urandom_range(0, 15));
            else cfg_rise[i*CW +: CW] = CW'($urandom_range(0, (p > 0) ? p - 1 : 0));
            cfg_width[i*CW +: CW] = CW'($urandom_range(0, 15));
         end
         cfg_invert = NCH'($urandom_range(0, 15));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
